// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared CPU constants for fetch state encoding and opcode decode
package fetch_stage_pkg;
    localparam int          PC_WIDTH    = 16;
    localparam logic [15:0] RESET_ADDR  = 16'h0000;
    localparam logic [15:0] NOP_ENC     = 16'h0000;
    localparam logic [3:0]  HALT_OPCODE = 4'h1;
    localparam logic [1:0]  S_FETCH  = 2'd0;
    localparam logic [1:0]  S_WAIT   = 2'd1;
    localparam logic [1:0]  S_HALTED = 2'd2;
    function automatic logic is_halt(input logic [15:0] i, input logic [3:0] op);
        return i[15:12] == op;
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response handshake
interface fetch_stage_if #(parameter int PC_W = 16);
    logic            req;
    logic [PC_W-1:0] addr;
    logic            valid;
    logic [15:0]     rdata;
    modport master (output req, addr, input valid, rdata);
    modport slave  (input req, addr, output valid, rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {data, pc} holding buffer for a response caught by a stall
module fetch_skid_buf #(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          drain,
    input  logic          clear,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] pin,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [AW-1:0] pc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (clear || drain) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
            pc    <= pin;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory requests, skid buffer and IF/ID register
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          PC_W     = PC_WIDTH,
    parameter logic [15:0] RESET_PC = RESET_ADDR,
    parameter logic [15:0] NOP_INST = NOP_ENC,
    parameter logic [3:0]  HALT_OP  = HALT_OPCODE
) (
    input  logic             clk,
    input  logic             rst,
    fetch_stage_if.master    imem,
    input  logic             stall,
    input  logic             redirect_en,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic [15:0]      inst,
    output logic [PC_W-1:0]  inst_pc,
    output logic             inst_valid,
    output logic             halted
);
    logic [1:0]      state;
    logic [PC_W-1:0] pc, fetch_pc, skid_pc, if_pc;
    logic [15:0]     skid_data, if_data;
    logic            drop, skid_valid, issue, rsp, take, load_skid, drain, if_load;

    always_comb begin
        issue     = state == S_FETCH && !skid_valid && !redirect_en && !rst;
        rsp       = state == S_WAIT && imem.valid;
        take      = rsp && !drop && !redirect_en;
        load_skid = take && stall;
        drain     = state == S_FETCH && skid_valid && !stall && !redirect_en;
        if_load   = (take && !stall) || drain;
        if_data   = drain ? skid_data : imem.rdata;
        if_pc     = drain ? skid_pc : fetch_pc;
    end

    assign imem.req  = issue;
    assign imem.addr = issue ? pc : '0;
    assign halted    = state == S_HALTED;

    fetch_skid_buf #(.DW(16), .AW(PC_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (load_skid),
        .drain (drain),
        .clear (redirect_en),
        .din   (imem.rdata),
        .pin   (fetch_pc),
        .valid (skid_valid),
        .data  (skid_data),
        .pc    (skid_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC[PC_W-1:0];
            fetch_pc   <= '0;
            drop       <= 1'b0;
            inst       <= NOP_INST;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else if (redirect_en) begin
            // an outstanding request still owes a response, which must be swallowed
            pc         <= redirect_pc;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            drop       <= drop || (state == S_WAIT && !imem.valid);
            state      <= (state == S_WAIT && !imem.valid) ? S_WAIT : S_FETCH;
            if (rsp) drop <= 1'b0;
        end else begin
            if (issue) begin
                fetch_pc <= pc;
                pc       <= pc + 1'b1;
                state    <= S_WAIT;
            end
            if (if_load) begin
                inst       <= if_data;
                inst_pc    <= if_pc;
                inst_valid <= 1'b1;
                state      <= is_halt(if_data, HALT_OP) ? S_HALTED : S_FETCH;
            end else if (!stall) begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
            end
            if (rsp && drop) begin
                drop  <= 1'b0;
                state <= S_FETCH;
            end
            if (load_skid) state <= S_FETCH;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage with a bench-driven instruction memory
module tb_fetch_stage;
    logic        clk = 0, rst = 1, stall = 0, redirect_en = 0;
    logic [15:0] redirect_pc = '0, inst, inst_pc;
    logic        inst_valid, halted;
    int          total = 0, bad = 0;
    logic        pend = 0, mem_en = 1, last_req = 0;
    logic [15:0] pend_addr = '0, last_addr = '0;

    fetch_stage_if #(.PC_W(16)) imem ();

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem(imem), .stall(stall),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] a);
        return a == 16'h0007 ? 16'h1000 : {4'h2, a[11:0]};
    endfunction

    // memory answers one cycle after a request unless mem_en holds it back
    task automatic cycle();
        imem.valid = pend && mem_en;
        imem.rdata = rom(pend_addr);
        #1;
        last_req  = imem.req;
        last_addr = imem.addr;
        @(posedge clk);
        if (imem.valid) pend = 0;
        if (last_req) begin pend = 1; pend_addr = last_addr; end
        #1;
        imem.valid = 0;
    endtask

    task automatic test_reset();
        imem.valid = 0;
        imem.rdata = '0;
        @(posedge clk); #1;
        total++; if (inst !== 16'h0000 || inst_valid !== 0 || inst_pc !== 0) begin bad++; $display("FAIL reset_ifid inst=%h v=%b pc=%h want 0000/0/0000", inst, inst_valid, inst_pc); end
        total++; if (imem.req !== 0 || imem.addr !== 0 || halted !== 0) begin bad++; $display("FAIL reset_req req=%b addr=%h halted=%b want 0/0000/0", imem.req, imem.addr, halted); end
        rst = 0;
    endtask

    task automatic test_straight();
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++; if (last_req !== 1 || last_addr !== 16'(i)) begin bad++; $display("FAIL straight_req%0d req=%b addr=%h want 1/%h", i, last_req, last_addr, 16'(i)); end
            total++; if (inst_valid !== 0 || inst !== 16'h0000) begin bad++; $display("FAIL straight_bubble%0d v=%b inst=%h want 0/0000", i, inst_valid, inst); end
            cycle();
            total++; if (inst_valid !== 1 || inst !== rom(16'(i)) || inst_pc !== 16'(i)) begin bad++; $display("FAIL straight_inst%0d v=%b inst=%h pc=%h want 1/%h/%h", i, inst_valid, inst, inst_pc, rom(16'(i)), 16'(i)); end
        end
    endtask

    task automatic test_stall_skid();
        stall = 1;
        cycle();
        total++; if (last_addr !== 16'h3 || inst_pc !== 16'h2 || inst_valid !== 1) begin bad++; $display("FAIL stall_req addr=%h pc=%h v=%b want 0003/0002/1", last_addr, inst_pc, inst_valid); end
        cycle();
        total++; if (inst_pc !== 16'h2 || inst !== rom(16'h2) || inst_valid !== 1) begin bad++; $display("FAIL stall_hold pc=%h inst=%h want 0002/%h", inst_pc, inst, rom(16'h2)); end
        cycle();
        total++; if (last_req !== 0 || inst_pc !== 16'h2) begin bad++; $display("FAIL skid_full_noreq req=%b pc=%h want 0/0002", last_req, inst_pc); end
        stall = 0;
        cycle();
        total++; if (last_req !== 0 || inst_pc !== 16'h3 || inst !== rom(16'h3) || inst_valid !== 1) begin bad++; $display("FAIL skid_drain req=%b pc=%h inst=%h want 0/0003/%h", last_req, inst_pc, inst, rom(16'h3)); end
        cycle();
        total++; if (last_req !== 1 || last_addr !== 16'h4) begin bad++; $display("FAIL after_skid_req req=%b addr=%h want 1/0004", last_req, last_addr); end
        cycle();
        total++; if (inst_pc !== 16'h4 || inst_valid !== 1) begin bad++; $display("FAIL after_skid_inst pc=%h v=%b want 0004/1", inst_pc, inst_valid); end
    endtask

    task automatic test_redirect_wait();
        mem_en = 0;
        cycle();
        total++; if (last_addr !== 16'h5) begin bad++; $display("FAIL rw_req addr=%h want 0005", last_addr); end
        redirect_en = 1; redirect_pc = 16'h0040;
        cycle();
        redirect_en = 0;
        total++; if (last_req !== 0 || inst_valid !== 0) begin bad++; $display("FAIL rw_redirect req=%b v=%b want 0/0", last_req, inst_valid); end
        mem_en = 1;
        cycle();
        total++; if (last_req !== 0 || inst_valid !== 0 || inst !== 16'h0000) begin bad++; $display("FAIL rw_stale_drop req=%b v=%b inst=%h want 0/0/0000", last_req, inst_valid, inst); end
        cycle();
        total++; if (last_req !== 1 || last_addr !== 16'h0040 || inst_valid !== 0) begin bad++; $display("FAIL rw_refetch req=%b addr=%h v=%b want 1/0040/0", last_req, last_addr, inst_valid); end
        cycle();
        total++; if (inst_valid !== 1 || inst_pc !== 16'h0040 || inst !== 16'h2040) begin bad++; $display("FAIL rw_target v=%b pc=%h inst=%h want 1/0040/2040", inst_valid, inst_pc, inst); end
    endtask

    task automatic test_redirect_coincident();
        cycle();
        total++; if (last_addr !== 16'h0041) begin bad++; $display("FAIL rc_req addr=%h want 0041", last_addr); end
        stall = 1; redirect_en = 1; redirect_pc = 16'h0006;
        cycle();
        redirect_en = 0;
        total++; if (inst_valid !== 0 || last_req !== 0) begin bad++; $display("FAIL rc_flush v=%b req=%b want 0/0", inst_valid, last_req); end
        stall = 0;
        cycle();
        total++; if (last_req !== 1 || last_addr !== 16'h0006) begin bad++; $display("FAIL rc_refetch req=%b addr=%h want 1/0006", last_req, last_addr); end
        cycle();
        total++; if (inst_pc !== 16'h0006 || inst_valid !== 1) begin bad++; $display("FAIL rc_inst pc=%h v=%b want 0006/1", inst_pc, inst_valid); end
    endtask

    task automatic test_halt();
        int reqs = 0;
        cycle();
        cycle();
        total++; if (inst !== 16'h1000 || inst_pc !== 16'h0007 || halted !== 1) begin bad++; $display("FAIL halt_inst inst=%h pc=%h halted=%b want 1000/0007/1", inst, inst_pc, halted); end
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_req) reqs++;
        end
        total++; if (reqs != 0 || halted !== 1 || inst_valid !== 0) begin bad++; $display("FAIL halt_quiet reqs=%0d halted=%b v=%b want 0/1/0", reqs, halted, inst_valid); end
        redirect_en = 1; redirect_pc = 16'h0010;
        cycle();
        redirect_en = 0;
        total++; if (halted !== 0 || last_req !== 0) begin bad++; $display("FAIL halt_release halted=%b req=%b want 0/0", halted, last_req); end
        cycle();
        total++; if (last_req !== 1 || last_addr !== 16'h0010) begin bad++; $display("FAIL halt_refetch req=%b addr=%h want 1/0010", last_req, last_addr); end
    endtask

    task automatic test_reset_mid_wait();
        mem_en = 0;
        #2 rst = 1;
        #1;
        total++; if (inst !== 16'h0000 || inst_valid !== 0 || inst_pc !== 0 || halted !== 0 || imem.req !== 0 || imem.addr !== 0) begin bad++; $display("FAIL async_reset inst=%h v=%b pc=%h halted=%b req=%b addr=%h want all zero", inst, inst_valid, inst_pc, halted, imem.req, imem.addr); end
        @(posedge clk); #1;
        mem_en = 1;
        cycle();
        total++; if (inst_valid !== 0 || last_req !== 0) begin bad++; $display("FAIL stale_in_reset v=%b req=%b want 0/0", inst_valid, last_req); end
        rst = 0;
        cycle();
        total++; if (last_req !== 1 || last_addr !== 16'h0000 || inst_valid !== 0) begin bad++; $display("FAIL post_reset_req req=%b addr=%h v=%b want 1/0000/0", last_req, last_addr, inst_valid); end
        cycle();
        total++; if (inst_valid !== 1 || inst_pc !== 16'h0000 || inst !== rom(16'h0)) begin bad++; $display("FAIL post_reset_inst v=%b pc=%h inst=%h want 1/0000/%h", inst_valid, inst_pc, inst, rom(16'h0)); end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_coincident();
        test_halt();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of decode; owns the PC and the IF/ID pipeline register whose inst output drives the decode stage's 16-bit inst input. Issues word-addressed requests to instruction memory over a req/valid handshake. Absorbs back-pressure with a one-entry skid buffer, applies branch/return redirects from execute, and stops fetching after a HALT instruction.

Parameters:
PC_W, 16, PC / instruction-memory address width (word address, +1 per instruction)
RESET_PC, 0, PC value loaded on reset
NOP_INST, 16'h0000, bubble encoding driven on inst when IF/ID is empty
HALT_OP, 4'h1, opcode (inst[15:12]) that halts fetch

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
imem_req  out  1  one-cycle request pulse; address sampled by memory this cycle
imem_addr  out  PC_W  request address, valid while imem_req=1
imem_valid  in  1  response strobe, ≥1 cycle after imem_req; exactly one per request
imem_rdata  in  16  instruction data, valid with imem_valid
stall  in  1  hazard unit: hold IF/ID contents this cycle
redirect_en  in  1  execute: taken BR/BRR/RET; flush and refetch
redirect_pc  in  PC_W  redirect target
inst  out  16  IF/ID instruction to decode
inst_pc  out  PC_W  address of inst
inst_valid  out  1  inst holds a real instruction
halted  out  1  fetch stopped on HALT

Behaviour:
- Reset (async, rst=1): state=FETCH, pc=RESET_PC, inst=NOP_INST, inst_pc=0, inst_valid=0, imem_req=0, imem_addr=0, halted=0, skid empty, drop=0.
- Registers: pc (next fetch address), fetch_pc (address of outstanding request), skid {valid, data, pc}, drop flag.
- FSM states: FETCH, WAIT, HALTED.
- FETCH, skid empty, redirect_en=0: imem_req=1, imem_addr=pc, fetch_pc<=pc, pc<=pc+1 (wraps modulo 2^PC_W) -> WAIT.
- FETCH, skid full: no request. If stall=0: IF/ID<=skid, skid cleared, state stays FETCH (request issued next cycle). If stall=1: hold.
- WAIT, imem_valid=0: no request; IF/ID becomes bubble (inst=NOP_INST, inst_valid=0) if stall=0, else holds.
- WAIT, imem_valid=1, drop=1: discard data, drop<=0 -> FETCH.
- WAIT, imem_valid=1, drop=0, stall=0: inst<=imem_rdata, inst_pc<=fetch_pc, inst_valid<=1. If imem_rdata[15:12]==HALT_OP -> HALTED, else -> FETCH.
- WAIT, imem_valid=1, drop=0, stall=1: IF/ID holds; skid<=rdata/fetch_pc -> FETCH.
- HALT detection also applies when the skid drains into IF/ID: that transfer -> HALTED instead of FETCH.
- HALTED: halted=1, no requests; IF/ID drains to bubble when stall=0.
- Fetch latency: imem_valid in cycle N places the instruction on inst in cycle N+1. Back-to-back throughput with 1-cycle memory: one instruction per 2 cycles.
- Redirect (highest priority, overrides stall, any state): pc<=redirect_pc, IF/ID<=bubble, skid cleared, halted<=0, request suppressed this cycle.
  - In WAIT with no imem_valid this cycle: drop<=1, stay WAIT.
  - In WAIT with imem_valid this cycle: data discarded -> FETCH.
  - Otherwise -> FETCH.
- Redirect while drop=1 already: pc updated, drop stays 1.
- inst_valid=0 guarantees inst==NOP_INST.

Decomposition:
- Shared CPU package: fetch state encoding (FETCH/WAIT/HALTED), NOP_INST and HALT_OP constants (shared with the controller's opcode decode), RESET_PC.
- One sub-module: fetch_skid_buf. One-entry {data, pc} buffer with load/drain/clear; async reset to empty.

Test Plan:
- Straight-line: reset, memory returns rdata 1 cycle after each req at addrs 0,1,2 -> inst_pc 0,1,2 with matching inst, inst_valid=1 on each response+1 cycle, bubbles between.
- Stall/skid: stall=1 during the response for addr 3 -> inst holds addr 2 instruction, no new req. Drop stall -> inst_pc=3 next cycle, then req addr 4.
- Redirect in WAIT: req addr 5 outstanding, redirect_en with redirect_pc=0x40 -> late response discarded, next req addr 0x40, inst_valid=0 until 0x40 returns.
- Redirect coincident with imem_valid and stall=1 -> data dropped, skid empty, next req addr=redirect_pc.
- HALT: memory returns 16'h1000 at addr 7 -> inst=16'h1000, halted=1, no further imem_req for 20 cycles. Redirect to 0x10 -> halted=0, req addr 0x10.
- Reset mid-WAIT: assert rst asynchronously between clk edges -> all outputs at reset values immediately. After release, first req addr=RESET_PC and the stale response is not issued to decode.
